mem_arbiter: RTL
================

# mem_arbiter

Shares the core's single Wishbone-style memory port between the instruction-fetch path and the load/store path driven by the control unit's `is_LS_o`, `we_mem_o` and `funct3_mem_o`. It arbitrates, formats byte-lane selects, write data and load data, and checks alignment. Misaligned or illegal-size data requests are rejected without a bus cycle and flagged for the trap logic. All requester-side and bus-side outputs are registered.

## Interface
- `ADDR_W`, 32, address width; the bus address is word-aligned.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `iport_req_i`  in  1  fetch request, level; held with `iport_addr_i` until a response.
- `iport_addr_i`  in  ADDR_W  fetch address.
- `iport_data_o`  out  32  fetched word; valid when `iport_ack_o` is high.
- `iport_ack_o` / `iport_err_o`  out  1  one-cycle response pulses.
- `dport_req_i`  in  1  load/store request, level; inputs held until a response.
- `dport_we_i`  in  1  1 = store.
- `dport_funct3_i`  in  3  access size/sign, RISC-V load/store encoding.
- `dport_addr_i`  in  ADDR_W  byte address.
- `dport_wdata_i`  in  32  store data, right-aligned.
- `dport_rdata_o`  out  32  load result, extended; valid when `dport_ack_o` is high.
- `dport_ack_o` / `dport_err_o`  out  1  one-cycle response pulses.
- `dport_misaligned_o`  out  1  qualifies `dport_err_o`: 1 = alignment fault, 0 = bus error or illegal size.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  bus cycle controls.
- `wb_adr_o`  out  ADDR_W  `{addr[ADDR_W-1:2],2'b00}`.
- `wb_sel_o`  out  4  byte lanes.
- `wb_dat_o`  out  32  lane-formatted write data.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`  in  1  bus termination.

## Operation
- **FSM states:** IDLE, BUS_I, BUS_D, RESP.
- **IDLE:** this is the only state that samples requests.
  - If only one port is requesting, that port wins.
  - If both are requesting, the data port wins, unless the previous grant was data; then the fetch port wins (alternating, so neither starves).
  - A winner whose request fails the checks goes straight to RESP with error, and no bus cycle is issued.
- **Fetch check:** `addr[1:0]` must be 0.
- **Data checks:**
  - funct3 011, 110 or 111, or store with funct3[2]=1 → illegal (`misaligned_o`=0).
  - Half-word with `addr[0]`=1, or word with `addr[1:0]`≠0 → misaligned (`misaligned_o`=1).
- **BUS_x:** `cyc`/`stb` are held high with stable address, sel and data until `wb_ack_i` or `wb_err_i`. On that edge, capture the read data and status, then go to RESP.
- **RESP:** pulse the winner's `ack_o` or `err_o` for exactly one cycle, then return to IDLE. Requests are ignored in RESP. A requester drops `req` at the end of its response cycle unless it is issuing a new request.
- **Byte-lane format:**
  - `sel`: byte = `0001<<a[1:0]`; half = `0011<<a[1:0]`; word = `1111`; fetch = `1111`.
  - `wb_dat_o`: byte replicated ×4; half replicated ×2; word unchanged.
- **Load data:**
  - Shift `wb_dat_i` right by `8*a[1:0]`.
  - Sign-extend from bit 7 or 15 when funct3[2]=0; zero-extend otherwise.
  - Word results pass through unchanged.
- **On error:** data outputs are 0.
- **Bus activity:** `wb_ack_i`/`wb_err_i` outside BUS_x are ignored. If `wb_ack_i` and `wb_err_i` are both high, error wins.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Asserting reset mid-transaction drops `cyc`/`stb` immediately (asynchronously) and produces no response. A late ack after reset is ignored.
- **Successful access:** request sampled at edge 0 → `cyc`/`stb` high in cycle 1 → `wb_ack_i` in cycle k≥1 → `ack_o` in cycle k+1 → IDLE in cycle k+2. With a zero-wait-state bus the minimum latency is 2 cycles and the throughput is one access per 3 cycles.
- **Rejected request:** request sampled at edge 0 → `err_o` in cycle 1, no bus activity.
- There is no bus timeout; the bus guarantees termination.

## Structure
- **Shared package `xyz_pkg`:**
  - funct3 size constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - Arbiter state enum.
  - Exception cause codes (load/store misaligned 4/6, access faults 1/5/7), which the trap logic maps from `err_o`/`misaligned_o`.
- **Sub-module `lsu_align`:** combinational; generates sel and write data, extracts and extends load data, and performs the alignment/illegal checks. It is instantiated once, on the data path.

## Test plan
- Zero-wait fetch at 0x100, bus returns 0xDEADBEEF → `wb_sel_o`=1111, `iport_ack_o` two cycles after the request, `iport_data_o`=0xDEADBEEF.
- LB at 0x203, `wb_dat_i`=0x80FF_0000 → `sel`=1000, `rdata`=0xFFFFFF80; repeat as LBU → 0x00000080.
- SH at 0x302, `wdata`=0x1234ABCD → `sel`=1100, `wb_dat_o`=0xABCDABCD, `wb_we_o`=1, `wb_adr_o`=0x300.
- LW at 0x401 → `dport_err_o` and `misaligned_o` in cycle 1, `wb_cyc_o` never high; funct3=011 → `err_o`=1, `misaligned_o`=0.
- Both ports requesting continuously → grants alternate D, I, D, I, with data first out of reset; `wb_err_i` on a data access → `dport_err_o`=1, `misaligned_o`=0.
- `rst_ni` low during BUS_D with a 3-wait-state bus → `cyc` drops immediately; the late ack produces no response and the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory-port arbiter.
// funct3 sizes, arbiter states and trap cause codes.
package mem_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_I = 2'd1,
    ST_BUS_D = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [3:0] CAUSE_INSTR_FAULT    = 4'd1;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

  // Trap cause for a data-port error, given direction
  // and the misaligned qualifier.
  function automatic logic [3:0] data_cause(
    input logic we,
    input logic mis
  );
    logic [3:0] c;
    c = CAUSE_LOAD_FAULT;
    unique case ({we, mis})
      2'b00: c = CAUSE_LOAD_FAULT;
      2'b01: c = CAUSE_LOAD_MISALIGN;
      2'b10: c = CAUSE_STORE_FAULT;
      2'b11: c = CAUSE_STORE_MISALIGN;
      default: c = CAUSE_LOAD_FAULT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter_lsu_align.sv
// Load/store lane formatting and access checks (combinational).
// In: we, funct3, addr_lo, wdata, bus_rdata. Out: sel, bus_wdata, rdata, illegal, misaligned.
module lsu_align
  import mem_arbiter_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata,
  output logic        illegal,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    sel       = 4'b1111;
    bus_wdata = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        sel       = 4'b0001 << addr_lo;
        bus_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        sel       = 4'b0011 << addr_lo;
        bus_wdata = {2{wdata[15:0]}};
      end
      default: begin
        sel       = 4'b1111;
        bus_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    illegal = (funct3 == 3'b011)
            | (funct3[2:1] == 2'b11)
            | (we & funct3[2]);
    misaligned = ~illegal
               & (((funct3[1:0] == 2'b01) & addr_lo[0])
               |  ((funct3[1:0] == 2'b10) & (|addr_lo)));
  end

  assign shifted = bus_rdata >> {addr_lo, 3'b000};

  always_comb begin
    rdata = shifted;
    unique case (1'b1)
      funct3 == F3_LB:  rdata = {{24{shifted[7]}}, shifted[7:0]};
      funct3 == F3_LBU: rdata = {24'd0, shifted[7:0]};
      funct3 == F3_LH:  rdata = {{16{shifted[15]}}, shifted[15:0]};
      funct3 == F3_LHU: rdata = {16'd0, shifted[15:0]};
      default:          rdata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter onto one Wishbone-style memory port.
// Ports: iport_* fetch side, dport_* load/store side, wb_* bus side.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              iport_req_i,
  input  logic [ADDR_W-1:0] iport_addr_i,
  output logic [31:0]       iport_data_o,
  output logic              iport_ack_o,
  output logic              iport_err_o,
  input  logic              dport_req_i,
  input  logic              dport_we_i,
  input  logic [2:0]        dport_funct3_i,
  input  logic [ADDR_W-1:0] dport_addr_i,
  input  logic [31:0]       dport_wdata_i,
  output logic [31:0]       dport_rdata_o,
  output logic              dport_ack_o,
  output logic              dport_err_o,
  output logic              dport_misaligned_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  arb_state_e  state_q;
  logic        last_d_q;
  logic        d_we_q;
  logic [2:0]  d_f3_q;
  logic [1:0]  d_alo_q;

  logic        idle;
  logic        al_we;
  logic [2:0]  al_f3;
  logic [1:0]  al_alo;
  logic [3:0]  al_sel;
  logic [31:0] al_wdat;
  logic [31:0] al_rdata;
  logic        al_ill;
  logic        al_mis;
  logic        grant_d;
  logic        grant_i;
  logic        i_bad;
  logic        bus_done;

  // In IDLE the checks see the live request; afterwards the
  // captured copy, so load extraction does not depend on the
  // requester keeping its inputs stable.
  always_comb begin
    idle     = (state_q == ST_IDLE);
    al_we    = idle ? dport_we_i          : d_we_q;
    al_f3    = idle ? dport_funct3_i      : d_f3_q;
    al_alo   = idle ? dport_addr_i[1:0]   : d_alo_q;
    grant_d  = idle & dport_req_i
             & (~iport_req_i | ~last_d_q);
    grant_i  = idle & iport_req_i & ~grant_d;
    i_bad    = |iport_addr_i[1:0];
    bus_done = wb_ack_i | wb_err_i;
  end

  lsu_align u_align (
    .we         (al_we),
    .funct3     (al_f3),
    .addr_lo    (al_alo),
    .wdata      (dport_wdata_i),
    .bus_rdata  (wb_dat_i),
    .sel        (al_sel),
    .bus_wdata  (al_wdat),
    .rdata      (al_rdata),
    .illegal    (al_ill),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= ST_IDLE;
      last_d_q           <= 1'b0;
      d_we_q             <= 1'b0;
      d_f3_q             <= '0;
      d_alo_q            <= '0;
      iport_data_o       <= '0;
      iport_ack_o        <= 1'b0;
      iport_err_o        <= 1'b0;
      dport_rdata_o      <= '0;
      dport_ack_o        <= 1'b0;
      dport_err_o        <= 1'b0;
      dport_misaligned_o <= 1'b0;
      wb_cyc_o           <= 1'b0;
      wb_stb_o           <= 1'b0;
      wb_we_o            <= 1'b0;
      wb_adr_o           <= '0;
      wb_sel_o           <= '0;
      wb_dat_o           <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            last_d_q <= 1'b1;
            d_we_q   <= dport_we_i;
            d_f3_q   <= dport_funct3_i;
            d_alo_q  <= dport_addr_i[1:0];
            if (al_ill | al_mis) begin
              state_q            <= ST_RESP;
              dport_err_o        <= 1'b1;
              dport_misaligned_o <= al_mis;
            end else begin
              state_q  <= ST_BUS_D;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= dport_we_i;
              wb_adr_o <= {dport_addr_i[ADDR_W-1:2], 2'b00};
              wb_sel_o <= al_sel;
              wb_dat_o <= dport_we_i ? al_wdat : '0;
            end
          end else if (grant_i) begin
            last_d_q <= 1'b0;
            if (i_bad) begin
              state_q     <= ST_RESP;
              iport_err_o <= 1'b1;
            end else begin
              state_q  <= ST_BUS_I;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_adr_o <= {iport_addr_i[ADDR_W-1:2], 2'b00};
              wb_sel_o <= 4'b1111;
              wb_dat_o <= '0;
            end
          end
        end
        ST_BUS_I: begin
          if (bus_done) begin
            state_q  <= ST_RESP;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            if (wb_err_i) begin
              iport_err_o <= 1'b1;
            end else begin
              iport_ack_o  <= 1'b1;
              iport_data_o <= wb_dat_i;
            end
          end
        end
        ST_BUS_D: begin
          if (bus_done) begin
            state_q  <= ST_RESP;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            if (wb_err_i) begin
              dport_err_o <= 1'b1;
            end else begin
              dport_ack_o   <= 1'b1;
              dport_rdata_o <= d_we_q ? '0 : al_rdata;
            end
          end
        end
        ST_RESP: begin
          state_q            <= ST_IDLE;
          iport_data_o       <= '0;
          iport_ack_o        <= 1'b0;
          iport_err_o        <= 1'b0;
          dport_rdata_o      <= '0;
          dport_ack_o        <= 1'b0;
          dport_err_o        <= 1'b0;
          dport_misaligned_o <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
